// File: rtl/accum_result_drain.sv
// Captures NUM_OLANES-lane accumulator vectors into a FIFO and streams them one lane per beat, narrowed to OUT_W bits.
// First beat valid one cycle after capture; out_ready low holds the beat; full FIFO drops input (sticky overflow). `RESULT_SAT_EN: saturate + sat_flag.
module accum_result_drain #(
   parameter int OWIDTH     = 32,
   parameter int NUM_OLANES = 8,
   parameter int OUT_W      = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_VECS   = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_OLANES*OWIDTH-1:0]    in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [OUT_W-1:0]                out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [$clog2(NUM_OLANES)-1:0]   out_lane,
   output logic                            out_last,
   output logic [$clog2(NUM_VECS)-1:0]     out_row,
   output logic                            out_done,
   output logic                            overflow
`ifdef RESULT_SAT_EN
   ,
   output logic                            sat_flag
`endif
);

   localparam int VEC_W  = NUM_OLANES * OWIDTH;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int LANE_W = $clog2(NUM_OLANES);
   localparam int ROW_W  = $clog2(NUM_VECS);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_OLANES - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_VECS - 1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [VEC_W-1:0]   mem [FIFO_DEPTH];
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic [AW:0]        count;
   logic               empty;
   logic               full;
   logic               push;
   logic               pop;
   logic               beat_acc;
   logic               last_beat;
   logic [VEC_W-1:0]   head_vec;
   logic [OUT_W-1:0]   narrowed;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign count    = wr_ptr - rd_ptr;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready = ~rst & ~full;
   assign push     = in_valid & in_ready;

   assign head_vec  = mem[rd_ptr[AW-1:0]];
   assign last_beat = (out_lane == LAST_LANE);
   assign beat_acc  = out_valid & out_ready;
   assign pop       = beat_acc & last_beat;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

`ifdef RESULT_SAT_EN
   logic signed [OWIDTH-1:0] lane_val;
   logic signed [OWIDTH-1:0] sat_max;
   logic signed [OWIDTH-1:0] sat_min;
   logic                     sat_hit;

   assign sat_max = {{(OWIDTH-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   assign sat_min = {{(OWIDTH-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   always_comb begin
      lane_val = head_vec[out_lane*OWIDTH +: OWIDTH];
      sat_hit  = 1'b1;
      if (lane_val > sat_max) begin
         narrowed = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (lane_val < sat_min) begin
         narrowed = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         narrowed = lane_val[OUT_W-1:0];
         sat_hit  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_flag <= 1'b0;
      end else if (beat_acc && sat_hit) begin
         sat_flag <= 1'b1;
      end
   end
`else
   // Two's-complement wrap: keep the low OUT_W bits of the head lane.
   assign narrowed = head_vec[out_lane*OWIDTH +: OUT_W];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            out_valid = 1'b1;
            out_data  = narrowed;
            out_last  = last_beat;
            // A push landing on the same edge keeps the stream going with no bubble.
            if (pop && (count == {{AW{1'b0}}, 1'b1}) && !push) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_lane <= '0;
         out_row  <= '0;
         out_done <= 1'b0;
         overflow <= 1'b0;
      end else begin
         out_done <= pop && (out_row == LAST_ROW);
         if (in_valid && !in_ready) begin
            overflow <= 1'b1;
         end
         if (beat_acc) begin
            if (last_beat) begin
               out_lane <= '0;
               out_row  <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
            end else begin
               out_lane <= out_lane + 1'b1;
            end
         end
      end
   end

endmodule
